// File: rtl/apb_regfile.sv
// APB3 register file: NUM_REGS x 32-bit, register 0 is a read-only ID, optional wait states.
// Define APB_REGFILE_PSTRB_EN to honour pstrb byte strobes on writes; otherwise writes are full-word.
module apb_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        apb_clk,
  input  logic        areset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam logic [6:0] LP_NUM_REGS = 7'(NUM_REGS);
  localparam logic [2:0] LP_WAIT     = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_wait_cnt;
  logic [7:0]  r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_regs [1:NUM_REGS-1];

  logic [5:0]  w_idx;
  logic        w_err;
  logic        w_setup;
  logic        w_active;
  logic        w_complete;
  logic        w_wr_en;
  logic [31:0] w_rd_data;
  logic [31:0] w_wr_mask;
  logic        w_unused;

  assign w_setup  = psel && !penable;
  assign w_active = psel && penable;
  assign w_idx    = r_addr[7:2];
  assign w_err    = (r_addr[1:0] != 2'b00)
                 || ({1'b0, w_idx} >= LP_NUM_REGS)
                 || (r_write && (w_idx == 6'd0));

`ifdef APB_REGFILE_PSTRB_EN
  assign w_wr_mask = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};
  assign w_unused  = ^paddr[31:8];
`else
  assign w_wr_mask = 32'hFFFF_FFFF;
  assign w_unused  = ^{paddr[31:8], r_strb};
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!w_active) begin
          w_state_next = ST_IDLE;
        end else if (r_wait_cnt == LP_WAIT) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Reset takes priority over a completion landing in the same cycle.
    pready  = w_complete && !areset;
    pslverr = pready && w_err;
    prdata  = (pready && !r_write && !w_err) ? w_rd_data : 32'h0;
  end

  assign w_wr_en = w_complete && r_write && !w_err;

  always_comb begin
    w_rd_data = (w_idx == 6'd0) ? ID_VALUE : 32'h0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_idx == 6'(i)) w_rd_data = r_regs[i];
    end
  end

  always_ff @(posedge apb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) begin
        r_wait_cnt <= 3'd0;
      end else if (w_active && !w_complete) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
    end
  end

  // Transfer attributes are datapath only; they are qualified by the FSM, so they need no reset.
  always_ff @(posedge apb_clk) begin
    if (r_state == ST_IDLE && w_setup) begin
      r_addr  <= paddr[7:0];
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  always_ff @(posedge apb_clk) begin
    if (areset) begin
      // NOTE: this storage is a flop array, not a RAM macro, so clearing it on reset is legal.
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= 32'h0;
    end else if (w_wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_idx == 6'(i)) r_regs[i] <= (r_regs[i] & ~w_wr_mask) | (r_wdata & w_wr_mask);
      end
    end
  end

endmodule

// File: doc/apb_regfile.md
APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 32-bit registers, legal 2..64.
REQ-002 Parameter WAIT_STATES, default 0: access-phase cycles inserted before PREADY, legal 0..7.
REQ-003 Parameter ID_VALUE, default 32'hA9B0_0001: constant returned by register 0.
REQ-004 apb_clk  input  1  sole clock, all state on rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 psel  input  1  APB select.
REQ-007 penable  input  1  APB enable, access phase.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pstrb  input  4  byte write strobes.
REQ-012 prdata  output  32  read data.
REQ-013 pready  output  1  transfer completion.
REQ-014 pslverr  output  1  transfer error, valid only with pready.

Function
REQ-015 FSM states SHALL be IDLE and ACCESS, with a 3-bit wait counter.
REQ-016 IDLE: psel=1 and penable=0 -> ACCESS, counter cleared, paddr/pwrite/pwdata/pstrb captured; any other input -> stay IDLE.
REQ-017 ACCESS: counter increments each cycle while psel=1 and penable=1; pready=1 combinationally when counter==WAIT_STATES.
REQ-018 Latency: pready asserts in the (WAIT_STATES+1)th access-phase cycle; WAIT_STATES=0 gives zero-wait APB.
REQ-019 Completion cycle -> IDLE; back-to-back setup in the next cycle is accepted with no dead cycle beyond the setup phase.
REQ-020 Register index = paddr[7:2]; error when paddr[1:0]!=0, index>=NUM_REGS, or write to index 0.
REQ-021 Writes commit only in the completion cycle, only when no error, only to the captured index.
REQ-022 Register 0 SHALL read ID_VALUE; registers 1..NUM_REGS-1 read their stored value.
REQ-023 prdata = selected register during a read completion without error, 32'h0 at all other times.
REQ-024 pslverr = 1 only in a completion cycle with error; 0 otherwise; an erroring transfer changes no state besides the FSM.
REQ-025 psel or penable deasserted while in ACCESS before completion (protocol violation): abort -> IDLE next cycle, no write, no pready.
REQ-026 pready, pslverr never asserted in IDLE.

Reset
REQ-027 areset=1 at a clock edge SHALL force IDLE, counter 0, registers 1..NUM_REGS-1 to 32'h0.
REQ-028 Outputs during and after reset until next completion: prdata=0, pready=0, pslverr=0.
REQ-029 Reset asserted mid-transfer SHALL abort it with no write, overriding any completion in the same cycle.

Configuration
REQ-030 Macro APB_REGFILE_PSTRB_EN defined: write updates only bytes whose pstrb bit is 1; pstrb=4'b0000 is a legal no-op write with pslverr=0.
REQ-031 Macro APB_REGFILE_PSTRB_EN undefined: pstrb port present but ignored, every legal write updates all 32 bits.

Verification
REQ-032 Reset, then read addr 0x00 at WAIT_STATES=0 -> pready in first access cycle, prdata=32'hA9B0_0001, pslverr=0.
REQ-033 Write 32'hDEAD_BEEF to 0x04, read 0x04 back-to-back at WAIT_STATES=3 -> pready on 4th access cycle each, readback 32'hDEAD_BEEF.
REQ-034 Write to 0x00, to 0x06 and to 0x40 (NUM_REGS=16) -> pslverr=1 with pready, subsequent reads show no change.
REQ-035 With APB_REGFILE_PSTRB_EN, reg 0x08 = 32'h1122_3344, write 32'hAABB_CCDD pstrb=4'b0101 -> reads 32'h11BB_33DD; without macro -> 32'hAABB_CCDD.
REQ-036 Drop penable in first access cycle at WAIT_STATES=2 -> no pready, register unchanged, next transfer completes normally.
REQ-037 Assert areset during access of a write to 0x0C -> reg 0x0C reads 32'h0 after reset, pready=0 during reset.
